accel_buffer_loader: RTL and testbench

- Fetch engine between the accelerator control FSM and external memory. One instance fills the weight buffer and a second fills the input buffer.
- On a start pulse it streams `load_len` words from memory, beginning at the address the FSM supplies, into an internal buffer. It then raises `buf_full`, which feeds the FSM's `WB_full`/`InB_full`.
- The PE reads the buffer through a 1-cycle synchronous port and releases it when finished.

---
 rtl/accel_buffer_loader.sv | 151 +++++++++++++++
 tb/tb_accel_buffer_loader.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_buffer_loader.sv
// Memory fetch engine that fills a local buffer with load_len words for the PE.
// The PE reads the buffer through a registered read port and hands it back with buf_release.
module accel_buffer_loader #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned MAX_OUT = 4,
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  load_len,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              buf_release,
    output logic              buf_full,
    output logic              busy,
    output logic              proto_err
);

    localparam int unsigned OUT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StFull
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_q, issue_d;
    logic [LEN_W-1:0]  wr_q, wr_d;
    logic [OUT_W-1:0]  out_q, out_d;

    logic [DATA_W-1:0] buffer [DEPTH];

    logic len_ok;
    logic in_flight;
    logic issue_fire;
    logic rsp_ok;
    logic rsp_bad;
    logic start_acc;
    logic start_err;

    assign mem_addr = base_q + ADDR_W'(issue_q);

    always_comb begin
        len_ok     = (load_len != '0) && (load_len <= LEN_W'(DEPTH));
        in_flight  = (state_q == StFetch) || (state_q == StDrain);
        mem_req    = (state_q == StFetch) && (issue_q < len_q) && (out_q < OUT_W'(MAX_OUT));
        issue_fire = mem_req & mem_gnt;
        // A response is only legal when it matches a request still in flight.
        rsp_ok     = mem_rvalid && in_flight && (out_q != '0);
        rsp_bad    = mem_rvalid && !rsp_ok;

        issue_d = issue_q + LEN_W'(issue_fire);
        wr_d    = wr_q + LEN_W'(rsp_ok);
        out_d   = out_q + OUT_W'(issue_fire) - OUT_W'(rsp_ok);

        start_acc = load_start && len_ok &&
                    ((state_q == StIdle) || ((state_q == StFull) && buf_release));
        start_err = load_start && !start_acc;

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (issue_d == len_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wr_d == len_q) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (start_acc) begin
                    state_d = StFetch;
                end else if (buf_release) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            base_q    <= '0;
            len_q     <= '0;
            issue_q   <= '0;
            wr_q      <= '0;
            out_q     <= '0;
            buf_full  <= 1'b0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                base_q  <= base_addr;
                len_q   <= load_len;
                issue_q <= '0;
                wr_q    <= '0;
                out_q   <= '0;
            end else begin
                issue_q <= issue_d;
                wr_q    <= wr_d;
                out_q   <= out_d;
            end
            buf_full <= (state_d == StFull);
            busy     <= (state_d == StFetch) || (state_d == StDrain);
            if (start_err || rsp_bad) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Storage has no reset so it maps onto a plain RAM.
    always_ff @(posedge clk) begin
        if (rsp_ok) begin
            buffer[wr_q[IDX_W-1:0]] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= buffer[rd_idx];
        end
    end

endmodule

// File: tb/tb_accel_buffer_loader.sv
// Directed bench for accel_buffer_loader: a behavioural memory answers requests in order
// with a programmable latency and returns the word address as data.
module tb_accel_buffer_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [8:0]  load_len = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b1;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_idx = '0;
    logic [15:0] rd_data;
    logic        buf_release = 1'b0;
    logic        buf_full;
    logic        busy;
    logic        proto_err;

    logic        mdl_rvalid = 1'b0;
    logic [15:0] mdl_rdata = '0;
    logic        stray_rvalid = 1'b0;
    logic [15:0] stray_rdata = '0;

    assign mem_rvalid = mdl_rvalid | stray_rvalid;
    assign mem_rdata  = stray_rvalid ? stray_rdata : mdl_rdata;

    int lat = 1;
    int cyc = 0;
    int rsp_cnt = 0;
    logic [15:0] q_data[$];
    int          q_due[$];
    logic [15:0] addr_log[$];
    int          gcyc_log[$];
    int          gout_log[$];

    int checks = 0;
    int fails = 0;

    accel_buffer_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .base_addr   (base_addr),
        .load_len    (load_len),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rd_en       (rd_en),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .buf_release (buf_release),
        .buf_full    (buf_full),
        .busy        (busy),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: decides this cycle's response and records this cycle's grant at negedge.
    always @(negedge clk) begin
        if (rst) begin
            q_data.delete();
            q_due.delete();
            mdl_rvalid = 1'b0;
        end else begin
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                mdl_rvalid = 1'b1;
                mdl_rdata  = q_data.pop_front();
                void'(q_due.pop_front());
                rsp_cnt++;
            end else begin
                mdl_rvalid = 1'b0;
            end
            if (mem_req && mem_gnt) begin
                q_data.push_back(mem_addr);
                q_due.push_back(cyc + lat);
                addr_log.push_back(mem_addr);
                gcyc_log.push_back(cyc);
                gout_log.push_back(q_due.size());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_load(input logic [15:0] b, input logic [8:0] l);
        @(negedge clk);
        base_addr  = b;
        load_len   = l;
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
    endtask

    // n counts rising edges starting with the one that samples load_start.
    task automatic wait_full(output int n);
        n = 1;
        while (!buf_full && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic read_buf(input logic [7:0] idx, output logic [15:0] d);
        @(negedge clk);
        rd_en  = 1'b1;
        rd_idx = idx;
        @(posedge clk);
        #1 d = rd_data;
        rd_en = 1'b0;
    endtask

    task automatic release_buf;
        @(negedge clk);
        buf_release = 1'b1;
        @(posedge clk);
        #1 buf_release = 1'b0;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, mem_addr, rd_data, buf_full, busy, proto_err} !== 35'd0) begin
            fails++;
            $display("FAIL reset_outputs: got req=%b addr=%h rd=%h full=%b busy=%b err=%b, want all 0",
                     mem_req, mem_addr, rd_data, buf_full, busy, proto_err);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({mem_req, buf_full, busy, proto_err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_idle: got req=%b full=%b busy=%b err=%b, want 0000",
                     mem_req, buf_full, busy, proto_err);
        end
    endtask

    task automatic test_full_chunk;
        int n, lb, bad_addr, bad_cyc;
        logic [15:0] d;
        lat = 1;
        lb  = addr_log.size();
        start_load(16'h0100, 9'd256);
        wait_full(n);
        checks++;
        if (n != 258) begin
            fails++;
            $display("FAIL full_latency: buf_full after %0d edges, want 258", n);
        end
        checks++;
        if (addr_log.size() - lb != 256) begin
            fails++;
            $display("FAIL full_count: %0d requests, want 256", addr_log.size() - lb);
        end
        bad_addr = 0;
        bad_cyc  = 0;
        for (int i = 0; i < 256 && lb + i < addr_log.size(); i++) begin
            if (addr_log[lb + i] !== 16'(16'h0100 + i)) bad_addr++;
            if (gcyc_log[lb + i] != gcyc_log[lb] + i) bad_cyc++;
        end
        checks++;
        if (bad_addr != 0) begin
            fails++;
            $display("FAIL full_addrs: %0d addresses off the 0x0100.. sequence, want 0", bad_addr);
        end
        checks++;
        if (bad_cyc != 0) begin
            fails++;
            $display("FAIL full_rate: %0d requests not back-to-back, want 0", bad_cyc);
        end
        checks++;
        if (busy !== 1'b0 || proto_err !== 1'b0) begin
            fails++;
            $display("FAIL full_flags: busy=%b err=%b, want 0 0", busy, proto_err);
        end
        read_buf(8'h10, d);
        checks++;
        if (d !== 16'h0110) begin
            fails++;
            $display("FAIL full_rd10: got %h want 0110", d);
        end
        read_buf(8'hFF, d);
        checks++;
        if (d !== 16'h01FF) begin
            fails++;
            $display("FAIL full_rdff: got %h want 01ff", d);
        end
        release_buf();
        checks++;
        if (buf_full !== 1'b0) begin
            fails++;
            $display("FAIL full_release: buf_full=%b want 0", buf_full);
        end
    endtask

    task automatic test_back_pressure;
        int n, lb, bad, mx;
        logic [15:0] d;
        lat = 8;
        lb  = addr_log.size();
        start_load(16'h0300, 9'd10);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || addr_log.size() - lb != 4) begin
            fails++;
            $display("FAIL bp_stall: req=%b issued=%0d, want req=0 issued=4",
                     mem_req, addr_log.size() - lb);
        end
        wait_full(n);
        checks++;
        if (buf_full !== 1'b1) begin
            fails++;
            $display("FAIL bp_done: buf_full=%b after %0d edges, want 1", buf_full, n);
        end
        mx = 0;
        for (int i = lb; i < gout_log.size(); i++) if (gout_log[i] > mx) mx = gout_log[i];
        checks++;
        if (mx != 4) begin
            fails++;
            $display("FAIL bp_outstanding: peak %0d, want 4", mx);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            read_buf(8'(i), d);
            if (d !== 16'(16'h0300 + i)) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_words: %0d of 10 words wrong, want 0", bad);
        end
        release_buf();
        lat = 1;
    endtask

    task automatic test_addr_wrap;
        int n, lb;
        logic [15:0] d;
        logic [15:0] exp_a[4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        lb = addr_log.size();
        start_load(16'hFFFE, 9'd4);
        wait_full(n);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lb + i >= addr_log.size() || addr_log[lb + i] !== exp_a[i]) begin
                fails++;
                $display("FAIL wrap_addr%0d: got %h want %h", i,
                         (lb + i < addr_log.size()) ? addr_log[lb + i] : 16'hxxxx, exp_a[i]);
            end
        end
        read_buf(8'd2, d);
        checks++;
        if (d !== 16'h0000) begin
            fails++;
            $display("FAIL wrap_buf2: got %h want 0000", d);
        end
    endtask

    task automatic test_release_restart;
        int n;
        logic [15:0] d;
        @(negedge clk);
        base_addr   = 16'h0200;
        load_len    = 9'd3;
        load_start  = 1'b1;
        buf_release = 1'b1;
        @(posedge clk);
        #1;
        load_start  = 1'b0;
        buf_release = 1'b0;
        checks++;
        if (buf_full !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_flags: full=%b busy=%b, want 0 1", buf_full, busy);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin
            fails++;
            $display("FAIL restart_req: req=%b addr=%h, want 1 0200", mem_req, mem_addr);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            fails++;
            $display("FAIL restart_err: proto_err=%b want 0", proto_err);
        end
        wait_full(n);
        read_buf(8'd1, d);
        checks++;
        if (d !== 16'h0201) begin
            fails++;
            $display("FAIL restart_data: got %h want 0201", d);
        end
        release_buf();
    endtask

    task automatic test_illegal_start;
        int n, lb;
        logic [15:0] d;
        start_load(16'h0000, 9'd0);
        checks++;
        if (proto_err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL illegal_len0: err=%b busy=%b, want 1 0", proto_err, busy);
        end
        apply_reset();
        start_load(16'h0000, 9'd300);
        checks++;
        if (proto_err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL illegal_len300: err=%b busy=%b, want 1 0", proto_err, busy);
        end
        apply_reset();
        checks++;
        if (proto_err !== 1'b0) begin
            fails++;
            $display("FAIL illegal_clear: proto_err=%b want 0", proto_err);
        end
        lb = addr_log.size();
        start_load(16'h0400, 9'd8);
        repeat (2) @(posedge clk);
        start_load(16'h0500, 9'd3);
        checks++;
        if (proto_err !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL illegal_busy: err=%b busy=%b, want 1 1", proto_err, busy);
        end
        wait_full(n);
        checks++;
        if (buf_full !== 1'b1 || addr_log.size() - lb != 8 ||
            addr_log[addr_log.size() - 1] !== 16'h0407) begin
            fails++;
            $display("FAIL illegal_fetch: full=%b issued=%0d last=%h, want 1 8 0407",
                     buf_full, addr_log.size() - lb, addr_log[addr_log.size() - 1]);
        end
        read_buf(8'd7, d);
        checks++;
        if (d !== 16'h0407) begin
            fails++;
            $display("FAIL illegal_word7: got %h want 0407", d);
        end
        release_buf();
    endtask

    task automatic test_reset_mid_fetch;
        int rb, k;
        apply_reset();
        start_load(16'h0600, 9'd20);
        rb = rsp_cnt;
        k  = 0;
        while (rsp_cnt - rb < 5 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (rsp_cnt - rb < 5) begin
            fails++;
            $display("FAIL midrst_progress: %0d responses, want at least 5", rsp_cnt - rb);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_abort: req=%b busy=%b, want 0 0", mem_req, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (proto_err !== 1'b0 || buf_full !== 1'b0) begin
            fails++;
            $display("FAIL midrst_quiet: err=%b full=%b, want 0 0", proto_err, buf_full);
        end
        @(negedge clk);
        stray_rvalid = 1'b1;
        stray_rdata  = 16'hDEAD;
        @(posedge clk);
        #1 stray_rvalid = 1'b0;
        checks++;
        if (proto_err !== 1'b1 || buf_full !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_stray: err=%b full=%b busy=%b, want 1 0 0",
                     proto_err, buf_full, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_chunk();
        test_back_pressure();
        test_addr_wrap();
        test_release_restart();
        test_illegal_start();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
